// File: rtl/ts_uart_framer_pkg.sv
// Shared constants and state types for the timestamp UART framer.
package ts_pkg;

    // Packet layout: sync, channel, 4 timestamp bytes (MSB first), XOR checksum.
    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         FRAME_BYTES      = 7;
    localparam int         TS_BYTES         = 4;

    // 50 MHz system clock divided down to 115200 baud.
    localparam int         DEFAULT_BAUD_DIV = 434;

    // Bit-level serializer states (one 8N1 character).
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } framer_state_t;

    // Byte sequencer: waiting for a record, or streaming a packet.
    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_t;

endpackage

// File: rtl/ts_uart_framer_if.sv
// Record handshake between the timestamp capture logic and the framer.
interface ts_uart_framer_if #(
    parameter int CHAN_WIDTH = 2,
    parameter int TS_WIDTH   = 32
);

    logic                  rec_valid;
    logic                  rec_ready;
    logic [CHAN_WIDTH-1:0] rec_chan;
    logic [TS_WIDTH-1:0]   rec_ts;

    // Upstream producer of records.
    modport master (
        output rec_valid,
        output rec_chan,
        output rec_ts,
        input  rec_ready
    );

    // Framer side.
    modport slave (
        input  rec_valid,
        input  rec_chan,
        input  rec_ts,
        output rec_ready
    );

endinterface

// File: rtl/ts_uart_framer_uart_tx_byte.sv
// 8N1 byte serializer. A start request is honoured when idle or on the
// final cycle of the stop bit, so consecutive bytes run with no gap.
module uart_tx_byte
    import ts_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       serialout,
    output logic       done
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BAUD_DIV - 1);

    framer_state_t    state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             serialout_reg;

    // Last cycle of the stop bit: the point where the next byte may be chained.
    assign done      = (state_reg == ST_STOP) && (cnt_reg == '0);
    assign serialout = serialout_reg;

    // Bit sequencing; every bit holds for BAUD_DIV clocks, line driven from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            serialout_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg     <= data;
                        serialout_reg <= 1'b0;
                        cnt_reg       <= CNT_LOAD;
                        state_reg     <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_reg == '0) begin
                        serialout_reg <= shift_reg[0];
                        shift_reg     <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg   <= '0;
                        cnt_reg       <= CNT_LOAD;
                        state_reg     <= ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == '0) begin
                        cnt_reg <= CNT_LOAD;
                        if (bit_idx_reg == 3'd7) begin
                            serialout_reg <= 1'b1;
                            state_reg     <= ST_STOP;
                        end else begin
                            serialout_reg <= shift_reg[0];
                            shift_reg     <= {1'b0, shift_reg[7:1]};
                            bit_idx_reg   <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_reg == '0) begin
                        if (start) begin
                            shift_reg     <= data;
                            serialout_reg <= 1'b0;
                            cnt_reg       <= CNT_LOAD;
                            state_reg     <= ST_START;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ts_uart_framer.sv
// Timestamp record framer: latches one record per handshake and streams it
// as a 7-byte packet (A5, chan, ts MSB..LSB, XOR checksum) over 8N1 serial.
// TS_WIDTH is fixed at 32 by the packet format; CHAN_WIDTH must be <= 8.
module ts_uart_framer
    import ts_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int TS_WIDTH   = 32,
    parameter int CHAN_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    ts_uart_framer_if.slave  rec,
    output logic             serialout,
    output logic             busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    seq_state_t            seq_state_reg;
    logic                  rec_ready_reg;
    logic                  busy_reg;
    logic [2:0]            byte_idx_reg;   // byte currently on the wire
    logic [CHAN_WIDTH-1:0] chan_reg;
    logic [TS_WIDTH-1:0]   ts_reg;
    logic [7:0]            csum_reg;       // XOR of bytes 1..n already loaded

    logic [7:0]            ts_byte [TS_BYTES];
    logic [7:0]            next_byte;
    logic                  accept;
    logic                  last_byte;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_done;

    // Timestamp split into bytes, most significant first.
    genvar gi;
    generate
        for (gi = 0; gi < TS_BYTES; gi++) begin : g_ts_bytes
            assign ts_byte[gi] = ts_reg[TS_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    assign accept    = (seq_state_reg == SEQ_IDLE) && rec.rec_valid && rec_ready_reg;
    assign last_byte = (byte_idx_reg == LAST_IDX);

    // The sync byte goes out on the acceptance edge itself so the start bit
    // appears the very next cycle; later bytes chain on the stop-bit end.
    assign tx_start = accept || ((seq_state_reg == SEQ_SEND) && tx_done && !last_byte);
    assign tx_data  = accept ? SYNC_BYTE : next_byte;

    // Byte following the one on the wire, taken from the latched record only.
    always_comb begin
        next_byte = csum_reg;
        case (byte_idx_reg)
            3'd0:    next_byte = 8'(chan_reg);
            3'd1:    next_byte = ts_byte[0];
            3'd2:    next_byte = ts_byte[1];
            3'd3:    next_byte = ts_byte[2];
            3'd4:    next_byte = ts_byte[3];
            default: next_byte = csum_reg;
        endcase
    end

    // Handshake, record capture, byte sequencing and checksum accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_state_reg <= SEQ_IDLE;
            rec_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            byte_idx_reg  <= '0;
            chan_reg      <= '0;
            ts_reg        <= '0;
            csum_reg      <= '0;
        end else begin
            case (seq_state_reg)
                SEQ_IDLE: begin
                    if (accept) begin
                        chan_reg      <= rec.rec_chan;
                        ts_reg        <= rec.rec_ts;
                        csum_reg      <= '0;
                        byte_idx_reg  <= '0;
                        rec_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        seq_state_reg <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (tx_done) begin
                        if (last_byte) begin
                            byte_idx_reg  <= '0;
                            rec_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            seq_state_reg <= SEQ_IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                            // Bytes 1..5 feed the checksum; byte 6 is the checksum.
                            if (byte_idx_reg < 3'd5) begin
                                csum_reg <= csum_reg ^ next_byte;
                            end
                        end
                    end
                end
                default: seq_state_reg <= SEQ_IDLE;
            endcase
        end
    end

    assign rec.rec_ready = rec_ready_reg;
    assign busy          = busy_reg;

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .data      (tx_data),
        .serialout (serialout),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_ts_uart_framer.sv
// Self-checking bench for ts_uart_framer: line activity is logged per cycle
// and compared against an ideal 8N1 waveform built from the packet rules.
module tb_ts_uart_framer;

    localparam int B     = 4;
    localparam int PKT   = 70 * B;
    localparam int NB    = 7;
    localparam int MAXC  = 12000;

    typedef logic [7:0] pkt_t [NB];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serialout;
    logic busy;

    ts_uart_framer_if #(.CHAN_WIDTH(2), .TS_WIDTH(32)) bus ();

    ts_uart_framer #(
        .BAUD_DIV   (B),
        .TS_WIDTH   (32),
        .CHAN_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rec       (bus.slave),
        .serialout (serialout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic sl [MAXC];
    logic rl [MAXC];
    logic bl [MAXC];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            sl[cyc] <= serialout;
            rl[cyc] <= bus.rec_ready;
            bl[cyc] <= busy;
        end
    end

    // Reference packet: sync, channel, timestamp MSB first, XOR of bytes 1..5.
    function automatic pkt_t make_packet(input logic [1:0] ch, input logic [31:0] ts);
        pkt_t p;
        p[0] = 8'hA5;
        p[1] = {6'b0, ch};
        for (int k = 0; k < 4; k++) p[2+k] = 8'(ts >> (8 * (3 - k)));
        p[6] = 8'h00;
        for (int k = 1; k < 6; k++) p[6] = p[6] ^ p[k];
        return p;
    endfunction

    // Ideal line level at a given cycle offset from the first start bit.
    function automatic logic ideal_level(input pkt_t p, input int off);
        int j;
        int bp;
        j  = off / (10 * B);
        bp = (off % (10 * B)) / B;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return p[j][bp-1];
    endfunction

    // Present a record and wait for acceptance; start = first start-bit cycle.
    task automatic offer(input logic [1:0] ch, input logic [31:0] ts, output int start);
        bit got;
        got = 0;
        start = -1;
        @(negedge clk);
        bus.rec_valid = 1'b1;
        bus.rec_chan  = ch;
        bus.rec_ts    = ts;
        for (int i = 0; i < 2 * PKT + 20 && !got; i++) begin
            if (bus.rec_ready === 1'b1) begin
                got   = 1;
                start = cyc + 1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: rec_ready never high, required 1");
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        bus.rec_valid = 1'b0;
    endtask

    // Compare the logged packet starting at 'start' against the model.
    task automatic check_packet(input int start, input pkt_t exp, input string name);
        int   glitches;
        int   hs_bad;
        logic [7:0] d;
        if (start < 1 || start + PKT + 2 >= MAXC) return;
        for (int i = 0; i < PKT + 20 && cyc <= start + PKT + 1; i++) @(negedge clk);
        checks++;
        if (cyc <= start + PKT + 1) begin
            errors++;
            $display("FAIL %s wait_timeout: cyc %0d, required > %0d", name, cyc, start + PKT + 1);
            return;
        end
        checks++;
        if (sl[start-1] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_before_start: got %b required 1", name, sl[start-1]);
        end
        glitches = 0;
        hs_bad   = 0;
        for (int o = 0; o < PKT; o++) begin
            if (sl[start+o] !== ideal_level(exp, o)) glitches++;
            if (rl[start+o] !== 1'b0 || bl[start+o] !== 1'b1) hs_bad++;
        end
        checks++;
        if (glitches != 0) begin
            errors++;
            $display("FAIL %s bit_timing: %0d cycles off ideal waveform, required 0", name, glitches);
        end
        checks++;
        if (hs_bad != 0) begin
            errors++;
            $display("FAIL %s ready_busy_in_flight: %0d bad cycles, required 0", name, hs_bad);
        end
        for (int j = 0; j < NB; j++) begin
            for (int b = 0; b < 8; b++) d[b] = sl[start + j*10*B + (b+1)*B + B/2];
            checks++;
            if (d !== exp[j]) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h required %02h", name, j, d, exp[j]);
            end
        end
        checks++;
        if (rl[start+PKT] !== 1'b1 || bl[start+PKT] !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: ready=%b busy=%b required ready=1 busy=0",
                     name, rl[start+PKT], bl[start+PKT]);
        end
    endtask

    task automatic test_reset();
        int viol;
        bus.rec_valid = 1'b0;
        bus.rec_chan  = '0;
        bus.rec_ts    = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (serialout !== 1'b1 || bus.rec_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ser=%b ready=%b busy=%b required 1 1 0",
                     serialout, bus.rec_ready, busy);
        end
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.rec_chan = 2'($urandom);
            bus.rec_ts   = $urandom;
            if (serialout !== 1'b1 || bus.rec_ready !== 1'b1 || busy !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d bad cycles, required 0", viol);
        end
        $display("test_reset: idle for 100 clocks, violations %0d", viol);
    endtask

    task automatic test_single();
        int s;
        offer(2'd2, 32'h12345678, s);
        drop_valid();
        check_packet(s, make_packet(2'd2, 32'h12345678), "single");
        $display("test_single: chan=2 ts=12345678 start at cycle %0d", s);
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        offer(2'd0, 32'h0, s1);
        offer(2'd3, 32'hFFFFFFFF, s2);
        drop_valid();
        check_packet(s1, make_packet(2'd0, 32'h0), "b2b_first");
        check_packet(s2, make_packet(2'd3, 32'hFFFFFFFF), "b2b_second");
        checks++;
        if (s2 - s1 != PKT + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d clocks required %0d", s2 - s1, PKT + 1);
        end
        $display("test_back_to_back: spacing %0d clocks", s2 - s1);
    endtask

    task automatic test_midchange();
        int s1;
        int s2;
        logic [31:0] r;
        r = $urandom;
        offer(2'd1, r, s1);
        repeat (100) @(negedge clk);
        bus.rec_ts = 32'hDEADBEEF;
        offer(2'd1, 32'hDEADBEEF, s2);
        drop_valid();
        check_packet(s1, make_packet(2'd1, r), "midchange_first");
        check_packet(s2, make_packet(2'd1, 32'hDEADBEEF), "midchange_second");
        $display("test_midchange: first ts=%08h then DEADBEEF", r);
    endtask

    task automatic test_reset_mid();
        int s;
        int s2;
        logic [31:0] ts;
        logic [1:0]  ch;
        // B3 = ts[23:16] = 0 so the line is low during its data bits.
        ts = {8'($urandom), 8'h00, 16'($urandom)};
        offer(2'd1, ts, s);
        drop_valid();
        for (int i = 0; i < 2 * PKT && cyc < s + 34 * B; i++) @(negedge clk);
        checks++;
        if (serialout !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_line: got %b required 0", serialout);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (serialout !== 1'b1 || bus.rec_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ser=%b ready=%b busy=%b required 1 1 0",
                     serialout, bus.rec_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ch = 2'($urandom);
        ts = $urandom;
        offer(ch, ts, s2);
        drop_valid();
        check_packet(s2, make_packet(ch, ts), "after_reset");
        $display("test_reset_mid: aborted packet at cycle %0d, resumed chan=%0d ts=%08h", s, ch, ts);
    endtask

    task automatic test_random();
        int s;
        logic [1:0]  ch;
        logic [31:0] ts;
        for (int n = 0; n < 4; n++) begin
            ch = 2'($urandom_range(0, 3));
            ts = $urandom;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            offer(ch, ts, s);
            drop_valid();
            check_packet(s, make_packet(ch, ts), "random");
            $display("test_random: chan=%0d ts=%08h start at cycle %0d", ch, ts, s);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_midchange();
        test_reset_mid();
        test_random();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ts_uart_framer.md
Name: ts_uart_framer

Overview:
- Downstream stage of the timestamp capture logic; drives the device `serialout` pin.
- Accepts one timestamp record per handshake: channel id plus free-running counter value.
- Frames each record as a fixed 7-byte packet: sync, channel, timestamp MSB first, XOR checksum.
- Transmits the packet as 8N1 asynchronous serial, LSB first.

Parameters:
- BAUD_DIV, 434, clocks per serial bit (50 MHz / 115200); legal range ≥ 2.
- TS_WIDTH, 32, timestamp width; fixed at 32 for the 4-byte packet format.
- CHAN_WIDTH, 2, channel id width; must be ≤ 8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rec_valid  in  1  record available
- rec_ready  out  1  framer can accept a record
- rec_chan  in  CHAN_WIDTH  channel id of record
- rec_ts  in  TS_WIDTH  timestamp of record
- serialout  out  1  UART TX line, idle high
- busy  out  1  packet in flight

Interface (already decided):
- One clock, `clk`.
- Reset `rst` is asynchronous and active-high.
- All outputs are registered.

Behaviour:
- Reset values:
  - serialout=1, rec_ready=1, busy=0
  - state=IDLE
  - baud counter=0, bit index=0, byte index=0
  - shift register and checksum cleared
- Handshake:
  - Transfer occurs on the rising edge where rec_valid && rec_ready.
  - rec_chan and rec_ts are latched on that edge.
  - On the next cycle rec_ready=0 and busy=1.
  - rec_ready stays 0 until the packet completes.
  - rec_valid while not ready has no effect; the upstream stage holds its data.
- Packet bytes:
  - B0 = 0xA5
  - B1 = rec_chan zero-extended to 8 bits
  - B2..B5 = rec_ts[31:24], [23:16], [15:8], [7:0]
  - B6 = B1^B2^B3^B4^B5
- State machine IDLE → START → DATA → STOP → (next byte: START | last byte: IDLE):
  - START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
  - Each bit lasts exactly BAUD_DIV clocks.
  - The baud counter loads BAUD_DIV-1 on entry to each bit and advances when it reaches 0.
- Timing:
  - The start bit of B0 appears on serialout the cycle after acceptance.
  - Stop bits are back-to-back into the next start bit; there are no inter-byte gaps.
  - Packet duration = 70*BAUD_DIV clocks, from the first cycle of serialout=0 to the last stop-bit cycle.
- Completion:
  - On the final cycle of B6's stop bit, the next edge sets rec_ready=1, busy=0 and state=IDLE.
  - A record offered in that same cycle is not accepted until rec_ready is observed high.
  - Minimum packet-to-packet spacing = 70*BAUD_DIV + 1 clocks.
- Checksum:
  - Accumulated as bytes are loaded; B6 always reflects the latched record.
  - Input changes after acceptance do not alter the packet in flight.
- Reset mid-packet:
  - Asserting rst aborts the packet immediately; serialout returns to 1 asynchronously.
  - After release the block is IDLE and ready; no partial resume.
- Stable outputs:
  - rec_chan/rec_ts changes while rec_valid=0 have no effect.
  - serialout never glitches; it comes directly from a flop.

Decomposition:
- Shared package ts_pkg:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES = 7
  - enum for framer states
  - default BAUD_DIV
- Sub-module uart_tx_byte:
  - Byte-level 8N1 serializer with start/done pulse, parameterized by BAUD_DIV.
  - The framer sequences bytes, builds the checksum and owns the handshake.

Test Plan (BAUD_DIV=4 for speed):
- Reset hold then release, no records → serialout=1, rec_ready=1, busy=0 for 100 clocks.
- chan=2, ts=0x12345678 → bytes A5,02,12,34,56,78,0A decoded; start bit the cycle after accept; 280 clocks total; rec_ready high again the cycle after the last stop bit.
- Back-to-back records: chan=0 ts=0 then chan=3 ts=0xFFFFFFFF with valid held → second packet A5,03,FF,FF,FF,FF,03 begins exactly 281 clocks after the first start bit.
- Change rec_ts to 0xDEADBEEF mid-packet with rec_valid high → packet in flight unchanged; second packet carries DEADBEEF with checksum 01^DE^AD^BE^EF = 0x23 for chan=1.
- Assert rst during B3's data bits → serialout=1 immediately; after release the next record produces a complete, correct packet.
- Bit timing check: every serialout transition aligned to multiples of BAUD_DIV from the first start edge; no transitions in IDLE.
